// File: rtl/alu_issue_ctrl.sv
// Single-issue front end for the 8-bit ALU: decodes one instruction, reads the
// 4-entry register file, drives the ALU, then writes back or resolves BEQ.
module alu_issue_ctrl #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2,
    parameter int IMM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_eq,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [REG_AW-1:0] rsp_rd,
    output logic              rsp_wb,
    output logic              branch_taken,
    output logic [IMM_W-1:0]  branch_target,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int          NREG   = 1 << REG_AW;
    localparam logic [2:0]  OP_BEQ = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Instruction fields; the 16-bit format fixes the bit positions.
    logic [2:0]        f_op;
    logic [REG_AW-1:0] f_rd;
    logic [REG_AW-1:0] f_rs;
    logic [REG_AW-1:0] f_rt;
    logic              f_use_imm;
    logic [IMM_W-1:0]  f_imm;

    assign f_op      = instr[15:13];
    assign f_rd      = instr[12:11];
    assign f_rs      = instr[10:9];
    assign f_use_imm = instr[8];
    assign f_imm     = instr[IMM_W-1:0];
    assign f_rt      = instr[REG_AW-1:0];

    logic [DATA_W-1:0] regs_reg [NREG];

    logic [2:0]        op_reg;
    logic [REG_AW-1:0] rd_reg;
    logic [IMM_W-1:0]  target_reg;
    logic [DATA_W-1:0] alu_a_reg, alu_b_reg;
    logic [2:0]        alu_ctrl_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_result_reg;
    logic [REG_AW-1:0] rsp_rd_reg;
    logic              rsp_wb_reg;
    logic              branch_taken_reg;
    logic [IMM_W-1:0]  branch_target_reg;

    logic              accept;
    logic              in_exec;
    logic              rsp_done;
    logic              is_beq_reg;
    logic [DATA_W-1:0] opa_next, opb_next;
    logic [NREG-1:0]   wr_en;

    assign accept     = instr_valid && (state_reg == IDLE);
    assign in_exec    = (state_reg == EXEC);
    assign rsp_done   = (state_reg == RESP) && rsp_ready;
    assign is_beq_reg = (op_reg == OP_BEQ);

    // BEQ compares reg[rd] against reg[rs]; its imm is the branch target.
    always_comb begin
        opa_next = regs_reg[f_rs];
        opb_next = f_use_imm ? DATA_W'(f_imm) : regs_reg[f_rt];
        if (f_op == OP_BEQ) begin
            opa_next = regs_reg[f_rd];
            opb_next = regs_reg[f_rs];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (instr_valid) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture at accept; ALU inputs then hold until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg       <= '0;
            rd_reg       <= '0;
            target_reg   <= '0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_ctrl_reg <= '0;
        end else if (accept) begin
            op_reg       <= f_op;
            rd_reg       <= f_rd;
            target_reg   <= f_imm;
            alu_a_reg    <= opa_next;
            alu_b_reg    <= opb_next;
            alu_ctrl_reg <= f_op;
        end
    end

    // Response registers: loaded at the EXEC edge, held until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg     <= 1'b0;
            rsp_result_reg    <= '0;
            rsp_rd_reg        <= '0;
            rsp_wb_reg        <= 1'b0;
            branch_taken_reg  <= 1'b0;
            branch_target_reg <= '0;
        end else if (in_exec) begin
            rsp_valid_reg <= 1'b1;
            rsp_rd_reg    <= rd_reg;
            if (is_beq_reg) begin
                rsp_result_reg    <= '0;
                rsp_wb_reg        <= 1'b0;
                branch_taken_reg  <= alu_eq;
                branch_target_reg <= target_reg;
            end else begin
                rsp_result_reg    <= alu_out;
                rsp_wb_reg        <= 1'b1;
                branch_taken_reg  <= 1'b0;
                branch_target_reg <= '0;
            end
        end else if (rsp_done) begin
            rsp_valid_reg    <= 1'b0;
            branch_taken_reg <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_wr_en
            assign wr_en[gi] = in_exec && !is_beq_reg && (rd_reg == REG_AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_en[i]) begin
                    regs_reg[i] <= alu_out;
                end
            end
        end
    end

    assign instr_ready   = (state_reg == IDLE);
    assign alu_a         = alu_a_reg;
    assign alu_b         = alu_b_reg;
    assign alu_ctrl      = alu_ctrl_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_result    = rsp_result_reg;
    assign rsp_rd        = rsp_rd_reg;
    assign rsp_wb        = rsp_wb_reg;
    assign branch_taken  = branch_taken_reg;
    assign branch_target = branch_target_reg;
    assign dbg_data      = regs_reg[dbg_sel];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a vector table of instructions with
// hand-computed results, plus backpressure and mid-EXEC reset sequences.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic [7:0]  alu_out;
    logic        alu_eq;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_result;
    logic [1:0]  rsp_rd;
    logic        rsp_wb;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_ctrl #(.DATA_W(8), .REG_AW(2), .IMM_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_out      (alu_out),
        .alu_eq       (alu_eq),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_rd       (rsp_rd),
        .rsp_wb       (rsp_wb),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .dbg_sel      (dbg_sel),
        .dbg_data     (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU. Off-BEQ the eq flag is deliberately 1 and on BEQ alu_out
    // is junk, so the stage must sample each only where it is meaningful.
    always_comb begin
        alu_out = 8'hEE;
        alu_eq  = 1'b1;
        case (alu_ctrl)
            3'd0: alu_out = alu_a + alu_b;
            3'd1: alu_out = alu_a - alu_b;
            3'd2: alu_out = alu_a & alu_b;
            3'd3: alu_out = alu_a | alu_b;
            3'd4: alu_out = alu_a ^ alu_b;
            3'd5: alu_out = alu_a & ~alu_b;
            3'd6: alu_out = alu_b - alu_a;
            default: alu_eq = (alu_a == alu_b);
        endcase
    end

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  result;
        logic [1:0]  rd;
        logic        wb;
        logic        taken;
        logic [7:0]  target;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    logic [7:0] exp_regs [4];

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic ui,
                                        input logic [7:0] imm);
        return {op, rd, rs, ui, imm};
    endfunction

    function automatic vec_t mk(input logic [15:0] i, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] r, input logic [1:0] rd, input logic wb,
                                input logic tk, input logic [7:0] tg);
        vec_t v;
        v.instr = i; v.a = a; v.b = b; v.result = r;
        v.rd = rd; v.wb = wb; v.taken = tk; v.target = tg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_regs();
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r);
            #1;
            chk($sformatf("dbg_r%0d", r), dbg_data, exp_regs[r]);
        end
    endtask

    task automatic wait_rsp(input string tag);
        int cyc;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_rsp_latency"}, cyc, 1);
    endtask

    // Issue one vector with rsp_ready already high, check EXEC operands and the response.
    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        cyc = 0;
        while (!instr_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("ready_before_issue", instr_ready, 1);
        instr       = v.instr;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr       = 16'hFFFF;
        chk("exec_instr_ready", instr_ready, 0);
        chk("exec_alu_a", alu_a, v.a);
        chk("exec_alu_b", alu_b, v.b);
        chk("exec_alu_ctrl", alu_ctrl, v.instr[15:13]);
        wait_rsp("vec");
        chk("rsp_result", rsp_result, v.result);
        chk("rsp_rd", rsp_rd, v.rd);
        chk("rsp_wb", rsp_wb, v.wb);
        chk("branch_taken", branch_taken, v.taken);
        chk("branch_target", branch_target, v.target);
        $display("txn %0d instr=%04h a=%02h b=%02h result=%02h rd=%0d wb=%0b taken=%0b target=%02h",
                 idx, v.instr, alu_a, alu_b, rsp_result, rsp_rd, rsp_wb, branch_taken, branch_target);
        @(posedge clk); #1;
        chk("rsp_cleared", rsp_valid, 0);
        chk("taken_cleared", branch_taken, 0);
        if (v.wb) exp_regs[v.rd] = v.result;
        check_regs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(enc(3'd0, 2'd1, 2'd0, 1'b1, 8'd5),   8'h00, 8'h05, 8'h05, 2'd1, 1'b1, 1'b0, 8'h00);
        vecs[1]  = mk(enc(3'd0, 2'd1, 2'd0, 1'b1, 8'd200), 8'h00, 8'd200, 8'd200, 2'd1, 1'b1, 1'b0, 8'h00);
        vecs[2]  = mk(enc(3'd0, 2'd2, 2'd0, 1'b1, 8'd100), 8'h00, 8'd100, 8'd100, 2'd2, 1'b1, 1'b0, 8'h00);
        vecs[3]  = mk(enc(3'd0, 2'd1, 2'd1, 1'b0, 8'd2),   8'd200, 8'd100, 8'd44, 2'd1, 1'b1, 1'b0, 8'h00);
        vecs[4]  = mk(enc(3'd6, 2'd3, 2'd1, 1'b0, 8'd2),   8'd44, 8'd100, 8'd56, 2'd3, 1'b1, 1'b0, 8'h00);
        vecs[5]  = mk(enc(3'd1, 2'd3, 2'd3, 1'b1, 8'd60),  8'd56, 8'd60, 8'd252, 2'd3, 1'b1, 1'b0, 8'h00);
        vecs[6]  = mk(enc(3'd0, 2'd0, 2'd0, 1'b1, 8'd7),   8'd0, 8'd7, 8'd7, 2'd0, 1'b1, 1'b0, 8'h00);
        vecs[7]  = mk(enc(3'd0, 2'd1, 2'd0, 1'b1, 8'd0),   8'd7, 8'd0, 8'd7, 2'd1, 1'b1, 1'b0, 8'h00);
        vecs[8]  = mk(enc(3'd7, 2'd0, 2'd1, 1'b0, 8'h40),  8'd7, 8'd7, 8'd0, 2'd0, 1'b0, 1'b1, 8'h40);
        vecs[9]  = mk(enc(3'd0, 2'd1, 2'd1, 1'b1, 8'd1),   8'd7, 8'd1, 8'd8, 2'd1, 1'b1, 1'b0, 8'h00);
        vecs[10] = mk(enc(3'd7, 2'd0, 2'd1, 1'b0, 8'h40),  8'd7, 8'd8, 8'd0, 2'd0, 1'b0, 1'b0, 8'h40);
        vecs[11] = mk(enc(3'd1, 2'd0, 2'd0, 1'b1, 8'd7),   8'd7, 8'd7, 8'd0, 2'd0, 1'b1, 1'b0, 8'h00);
        vecs[12] = mk(enc(3'd0, 2'd1, 2'd0, 1'b1, 8'hF0),  8'h00, 8'hF0, 8'hF0, 2'd1, 1'b1, 1'b0, 8'h00);
        vecs[13] = mk(enc(3'd0, 2'd2, 2'd0, 1'b1, 8'h3C),  8'h00, 8'h3C, 8'h3C, 2'd2, 1'b1, 1'b0, 8'h00);
        vecs[14] = mk(enc(3'd2, 2'd3, 2'd1, 1'b0, 8'd2),   8'hF0, 8'h3C, 8'h30, 2'd3, 1'b1, 1'b0, 8'h00);
        vecs[15] = mk(enc(3'd3, 2'd3, 2'd1, 1'b0, 8'd2),   8'hF0, 8'h3C, 8'hFC, 2'd3, 1'b1, 1'b0, 8'h00);
        vecs[16] = mk(enc(3'd4, 2'd3, 2'd1, 1'b0, 8'd2),   8'hF0, 8'h3C, 8'hCC, 2'd3, 1'b1, 1'b0, 8'h00);
        vecs[17] = mk(enc(3'd5, 2'd3, 2'd1, 1'b0, 8'd2),   8'hF0, 8'h3C, 8'hC0, 2'd3, 1'b1, 1'b0, 8'h00);
        for (int r = 0; r < 4; r++) exp_regs[r] = 8'h00;

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        rsp_ready   = 1'b1;
        dbg_sel     = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("reset_instr_ready", instr_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_rsp_wb", rsp_wb, 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_alu_b", alu_b, 0);
        chk("reset_alu_ctrl", alu_ctrl, 0);
        chk("reset_branch_taken", branch_taken, 0);
        chk("reset_branch_target", branch_target, 0);
        check_regs();

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        // Backpressure: r0 = r2 + 0x10 held for 5 cycles while r3 = r0 + 1 waits.
        rsp_ready   = 1'b0;
        instr       = enc(3'd0, 2'd0, 2'd2, 1'b1, 8'h10);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr = enc(3'd0, 2'd3, 2'd0, 1'b1, 8'h01);
        wait_rsp("bp");
        for (int c = 0; c < 5; c++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_result", rsp_result, 8'h4C);
            chk("bp_instr_ready", instr_ready, 0);
            @(posedge clk); #1;
        end
        $display("txn bp hold result=%02h rd=%0d valid=%0b", rsp_result, rsp_rd, rsp_valid);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_released_valid", rsp_valid, 0);
        chk("bp_idle_ready", instr_ready, 1);
        exp_regs[0] = 8'h4C;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("bp_second_accepted", instr_ready, 0);
        chk("bp_second_alu_a", alu_a, 8'h4C);
        chk("bp_second_alu_b", alu_b, 8'h01);
        wait_rsp("bp2");
        chk("bp_second_result", rsp_result, 8'h4D);
        chk("bp_second_rd", rsp_rd, 2'd3);
        $display("txn bp second result=%02h rd=%0d", rsp_result, rsp_rd);
        @(posedge clk); #1;
        exp_regs[3] = 8'h4D;
        check_regs();

        // Reset during EXEC of r2 = r0(0x4C)... use r2 = 0x55 path via r0 cleared first.
        run_vec(100, mk(enc(3'd1, 2'd0, 2'd0, 1'b0, 8'd0), 8'h4C, 8'h4C, 8'h00, 2'd0, 1'b1, 1'b0, 8'h00));
        instr       = enc(3'd0, 2'd2, 2'd0, 1'b1, 8'h55);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("mr_in_exec_alu_b", alu_b, 8'h55);
        rst_n = 1'b0;
        #1;
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_alu_b", alu_b, 0);
        chk("mr_alu_ctrl", alu_ctrl, 0);
        for (int r = 0; r < 4; r++) exp_regs[r] = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mr_after_rsp_valid", rsp_valid, 0);
        chk("mr_after_instr_ready", instr_ready, 1);
        $display("txn reset abort rsp_valid=%0b instr_ready=%0b", rsp_valid, instr_ready);
        check_regs();
        run_vec(101, mk(enc(3'd0, 2'd2, 2'd2, 1'b1, 8'h11), 8'h00, 8'h11, 8'h11, 2'd2, 1'b1, 1'b0, 8'h00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
